alu_operand_stage: RTL
======================

// Module: alu_operand_stage
// PURPOSE
//  ID/EX pipeline register directly upstream of the 32-bit ALU. Captures a decoded instruction and
//  selects the operands (rs1/PC/zero -> a, rs2/imm -> b), with optional forwarding. Presents
//  ALUOp/ALUControl/a/b to the ALU one cycle later. Uses a valid/ready handshake with stall and flush.
// PARAMETERS
//  XLEN      32  datapath width
//  REG_AW     5  register address width
// PORTS
//  clk           in   1      clock, rising edge
//  rst_n         in   1      asynchronous active-low reset
//  flush         in   1      kill the held entry and any entry accepted this cycle
//  in_valid      in   1      decoder presents an instruction
//  in_ready      out  1      stage can accept this cycle
//  in_pc         in   XLEN   instruction PC
//  in_rs1_data   in   XLEN   register-file read port 1
//  in_rs2_data   in   XLEN   register-file read port 2
//  in_imm        in   XLEN   sign-extended immediate
//  in_rs1_addr   in   REG_AW source 1 index
//  in_rs2_addr   in   REG_AW source 2 index
//  in_rd_addr    in   REG_AW destination index
//  in_alu_op     in   3      ALUOp class (000 ld/st, 001 branch, 010 R-type)
//  in_alu_ctrl   in   4      ALUControl code (ADD 0000 .. SLTU 1001)
//  in_a_sel      in   2      00 rs1, 01 PC, 10 zero, 11 reserved (= rs1)
//  in_b_sel      in   1      0 rs2, 1 imm
//  exm_wr/_rd/_data in 1/REG_AW/XLEN  EX/MEM forward source (FORWARDING_EN only)
//  wb_wr/_rd/_data  in 1/REG_AW/XLEN  MEM/WB forward source (FORWARDING_EN only)
//  out_valid     out  1      entry valid toward ALU
//  out_ready     in   1      downstream accepts
//  alu_op        out  3      to ALU ALUOp
//  alu_ctrl      out  4      to ALU ALUControl
//  op_a, op_b    out  XLEN   to ALU a, b
//  out_rs2_data  out  XLEN   forwarded rs2 (store data)
//  out_rd_addr   out  REG_AW destination index
//  out_pc        out  XLEN   PC (branch target calculation)
// BEHAVIOUR
//  - Reset: out_valid=0; all data outputs 0; alu_op=000; alu_ctrl=0000 (ADD).
//  - Single-entry register; in_ready = !out_valid | out_ready (combinational).
//  - Accept when in_valid & in_ready: all outputs are registered next edge; latency is 1 cycle.
//  - Hold when out_valid & !out_ready: all outputs are stable; inputs are ignored.
//  - out_valid next = flush ? 0 : (accept ? 1 : (out_ready ? 0 : out_valid)).
//  - Flush beats accept in the same cycle. Data registers may load but out_valid=0.
//  - op_a = a_sel mux of forwarded rs1 / in_pc / 0; op_b = in_b_sel ? in_imm : forwarded rs2.
//  - Address x0 always reads 0 and is never forwarded, even if a source writes rd=0.
//  - All arithmetic is pass-through; no width change. PC is not offset here.
//  - Reset asserted mid-hold: the entry is dropped immediately (async); out_valid falls with no
//    clock edge.
// CONFIGURATION
//  FORWARDING_EN defined:
//    - Operand forwarding at capture. EX/MEM match (exm_wr & exm_rd==rsX & rsX!=0) wins over a
//      MEM/WB match, which wins over register-file data.
//    - During a hold, a MEM/WB match refreshes the held rs1/rs2 value and the op_a/op_b derived
//      from it, so a retiring producer is not lost.
//  FORWARDING_EN undefined:
//    - Forward ports are unused. Operands come from the register file only; the hazard unit
//      upstream must stall.
// STRUCTURE
//  - rv32i_pkg: alu_op_t (3-bit) and alu_ctrl_t (4-bit ADD..SLTU) enums, a_sel_t and b_sel_t
//    enums, XLEN and REG_AW constants.
//  - Sub-module fwd_sel: one instance per source operand.
//    - Inputs: rs addr, rf data, the two forward sources.
//    - Output: selected data.
// TESTING
//  1. Reset, then ADD (a_sel=00, b_sel=0, rs1=5, rs2=7), out_ready=1 -> next cycle out_valid=1,
//     op_a=5, op_b=7, alu_op=010, alu_ctrl=0000.
//  2. out_ready=0 for 3 cycles with in_valid high -> in_ready=0, outputs frozen; out_ready=1 ->
//     next instruction accepted the same cycle.
//  3. flush together with accept -> out_valid=0 next cycle. flush while holding -> entry dropped,
//     in_ready=1.
//  4. FORWARDING_EN: rs1=3, exm_rd=3 data 0xAAAA, wb_rd=3 data 0xBBBB -> op_a=0xAAAA.
//     rs1=0, exm_rd=0 -> op_a=0.
//  5. a_sel=01, b_sel=1, pc=0x100, imm=0xFFFFFFFC -> op_a=0x100, op_b=0xFFFFFFFC.
//     a_sel=10 -> op_a=0.
//  6. rst_n low mid-hold -> out_valid=0 asynchronously; after release in_ready=1.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared RV32I decode types and datapath constants for the ID/EX stage.
package rv32i_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;

  typedef enum logic [2:0] {
    AluOpLdSt   = 3'b000,
    AluOpBranch = 3'b001,
    AluOpRType  = 3'b010
  } alu_op_t;

  typedef enum logic [3:0] {
    AluAdd  = 4'b0000,
    AluSub  = 4'b0001,
    AluAnd  = 4'b0010,
    AluOr   = 4'b0011,
    AluXor  = 4'b0100,
    AluSll  = 4'b0101,
    AluSrl  = 4'b0110,
    AluSra  = 4'b0111,
    AluSlt  = 4'b1000,
    AluSltu = 4'b1001
  } alu_ctrl_t;

  typedef enum logic [1:0] {
    ASelRs1  = 2'b00,
    ASelPc   = 2'b01,
    ASelZero = 2'b10,
    ASelRsvd = 2'b11
  } a_sel_t;

  typedef enum logic {
    BSelRs2 = 1'b0,
    BSelImm = 1'b1
  } b_sel_t;

endpackage

// File: rtl/fwd_sel.sv
// Source-operand select: x0 forced to zero, then (with FORWARDING_EN defined)
// EX/MEM result over MEM/WB result over register-file data.
module fwd_sel
  import rv32i_pkg::*;
(
  input  logic [REG_AW-1:0] rs_addr,
  input  logic [XLEN-1:0]   rf_data,
  input  logic              exm_wr,
  input  logic [REG_AW-1:0] exm_rd,
  input  logic [XLEN-1:0]   exm_data,
  input  logic              wb_wr,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  output logic [XLEN-1:0]   sel_data
);

  // Priority select; x0 is never forwarded even if a producer targets rd=0.
  always_comb begin
    sel_data = rf_data;
    if (rs_addr == '0) begin
      sel_data = '0;
    end
`ifdef FORWARDING_EN
    else if (exm_wr && (exm_rd == rs_addr)) begin
      sel_data = exm_data;
    end else if (wb_wr && (wb_rd == rs_addr)) begin
      sel_data = wb_data;
    end
`endif
  end

`ifndef FORWARDING_EN
  logic unused_fwd;
  assign unused_fwd = ^{exm_wr, exm_rd, exm_data, wb_wr, wb_rd, wb_data};
`endif

endmodule

// File: rtl/alu_operand_stage.sv
// ID/EX register in front of the ALU: single entry, valid/ready with stall and flush.
// Optional operand forwarding is enabled by defining FORWARDING_EN.
module alu_operand_stage
  import rv32i_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   in_pc,
  input  logic [XLEN-1:0]   in_rs1_data,
  input  logic [XLEN-1:0]   in_rs2_data,
  input  logic [XLEN-1:0]   in_imm,
  input  logic [REG_AW-1:0] in_rs1_addr,
  input  logic [REG_AW-1:0] in_rs2_addr,
  input  logic [REG_AW-1:0] in_rd_addr,
  input  logic [2:0]        in_alu_op,
  input  logic [3:0]        in_alu_ctrl,
  input  logic [1:0]        in_a_sel,
  input  logic              in_b_sel,
  input  logic              exm_wr,
  input  logic [REG_AW-1:0] exm_rd,
  input  logic [XLEN-1:0]   exm_data,
  input  logic              wb_wr,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2:0]        alu_op,
  output logic [3:0]        alu_ctrl,
  output logic [XLEN-1:0]   op_a,
  output logic [XLEN-1:0]   op_b,
  output logic [XLEN-1:0]   out_rs2_data,
  output logic [REG_AW-1:0] out_rd_addr,
  output logic [XLEN-1:0]   out_pc
);

  logic              valid_q, valid_d;
  logic              accept;
  logic [XLEN-1:0]   rs1_fwd, rs2_fwd;
  logic [XLEN-1:0]   rs1_q, rs1_d;
  logic [XLEN-1:0]   rs2_q, rs2_d;
  logic [XLEN-1:0]   pc_q, imm_q;
  logic [REG_AW-1:0] rd_q;
  alu_op_t           alu_op_q;
  alu_ctrl_t         alu_ctrl_q;
  a_sel_t            a_sel_q;
  b_sel_t            b_sel_q;

  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  fwd_sel u_fwd_rs1 (
    .rs_addr  (in_rs1_addr),
    .rf_data  (in_rs1_data),
    .exm_wr   (exm_wr),
    .exm_rd   (exm_rd),
    .exm_data (exm_data),
    .wb_wr    (wb_wr),
    .wb_rd    (wb_rd),
    .wb_data  (wb_data),
    .sel_data (rs1_fwd)
  );

  fwd_sel u_fwd_rs2 (
    .rs_addr  (in_rs2_addr),
    .rf_data  (in_rs2_data),
    .exm_wr   (exm_wr),
    .exm_rd   (exm_rd),
    .exm_data (exm_data),
    .wb_wr    (wb_wr),
    .wb_rd    (wb_rd),
    .wb_data  (wb_data),
    .sel_data (rs2_fwd)
  );

  // Flush beats accept; a transfer without a new accept empties the stage.
  always_comb begin
    valid_d = valid_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d = 1'b1;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

`ifdef FORWARDING_EN
  logic              hold;
  logic [REG_AW-1:0] rs1_addr_q, rs2_addr_q;

  assign hold = valid_q && !out_ready;

  // Source operands: capture on accept; while stalled, pick up a retiring MEM/WB producer.
  always_comb begin
    rs1_d = rs1_q;
    rs2_d = rs2_q;
    if (accept) begin
      rs1_d = rs1_fwd;
      rs2_d = rs2_fwd;
    end else if (hold && wb_wr) begin
      if ((wb_rd == rs1_addr_q) && (rs1_addr_q != '0)) rs1_d = wb_data;
      if ((wb_rd == rs2_addr_q) && (rs2_addr_q != '0)) rs2_d = wb_data;
    end
  end

  // Source indices kept only so a stalled entry can be refreshed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rs1_addr_q <= '0;
      rs2_addr_q <= '0;
    end else if (accept) begin
      rs1_addr_q <= in_rs1_addr;
      rs2_addr_q <= in_rs2_addr;
    end
  end
`else
  // Source operands: capture on accept only.
  always_comb begin
    rs1_d = rs1_q;
    rs2_d = rs2_q;
    if (accept) begin
      rs1_d = rs1_fwd;
      rs2_d = rs2_fwd;
    end
  end
`endif

  // Valid flag and operand state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      rs1_q   <= '0;
      rs2_q   <= '0;
    end else begin
      valid_q <= valid_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
    end
  end

  // Decoded control and pass-through fields; these may load under flush, valid stays low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= '0;
      imm_q      <= '0;
      rd_q       <= '0;
      alu_op_q   <= AluOpLdSt;
      alu_ctrl_q <= AluAdd;
      a_sel_q    <= ASelRs1;
      b_sel_q    <= BSelRs2;
    end else if (accept) begin
      pc_q       <= in_pc;
      imm_q      <= in_imm;
      rd_q       <= in_rd_addr;
      alu_op_q   <= alu_op_t'(in_alu_op);
      alu_ctrl_q <= alu_ctrl_t'(in_alu_ctrl);
      a_sel_q    <= a_sel_t'(in_a_sel);
      b_sel_q    <= b_sel_t'(in_b_sel);
    end
  end

  // Operand muxes sit after the flops so a refreshed rs1/rs2 propagates to op_a/op_b.
  always_comb begin
    case (a_sel_q)
      ASelPc:   op_a = pc_q;
      ASelZero: op_a = '0;
      default:  op_a = rs1_q;  // reserved encoding behaves as rs1
    endcase
    op_b = (b_sel_q == BSelImm) ? imm_q : rs2_q;
  end

  assign out_valid    = valid_q;
  assign alu_op       = alu_op_q;
  assign alu_ctrl     = alu_ctrl_q;
  assign out_rs2_data = rs2_q;
  assign out_rd_addr  = rd_q;
  assign out_pc       = pc_q;

endmodule
